// File: rtl/mc_path_gen.sv
// Monte Carlo path generator: geometric-Brownian price walk with a fixed-point
// multiplicative update, one step per cycle, emitting each path's terminal price.
module mc_path_gen #(
  parameter int          PW        = 12,
  parameter int          GF        = 14,
  parameter logic [31:0] LFSR_INIT = 32'hACE12468
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [PW-1:0] s0_i,
  input  logic [15:0]   drift_i,
  input  logic [11:0]   vol_i,
  input  logic [7:0]    n_steps_i,
  input  logic [15:0]   num_paths_i,
  input  logic [31:0]   seed_i,
  output logic [PW-1:0] path_o,
  output logic          path_valid_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam int          PRODW     = PW + 16;

  typedef enum logic [1:0] {IDLE, STEP, EMIT, DONE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] s_q, s_d, s0_q, s0_d, path_q, path_d;
  logic [15:0]   drift_q, drift_d, npaths_q, npaths_d, pcnt_q, pcnt_d;
  logic [11:0]   vol_q, vol_d;
  logic [7:0]    nsteps_q, nsteps_d, step_q, step_d;
  logic [31:0]   lfsr_q, lfsr_d, lfsr_nxt;
  logic          pv_q, pv_d, done_q, done_d;

  // Datapath: Z from the current LFSR, growth factor g, next price f(S)
  logic [5:0]             nib_sum;
  logic signed [25:0]     z_s, vz_s, g_raw;
  logic [15:0]            g_cl;
  logic [PRODW-1:0]       prod;
  logic [PRODW-GF-1:0]    prod_sh;
  logic [PW-1:0]          f_s;

  always_comb begin
    nib_sum = 6'({2'b0, lfsr_q[3:0]}) + 6'({2'b0, lfsr_q[7:4]})
            + 6'({2'b0, lfsr_q[11:8]}) + 6'({2'b0, lfsr_q[15:12]});
    z_s     = $signed({20'b0, nib_sum}) - 26'sd30;
    vz_s    = $signed({14'b0, vol_q}) * z_s;
    g_raw   = (26'sd1 <<< GF) + $signed({{10{drift_q[15]}}, drift_q}) + vz_s;
    if (g_raw < 0)               g_cl = 16'd0;
    else if (g_raw > 26'sd65535) g_cl = 16'hFFFF;
    else                         g_cl = g_raw[15:0];
    prod    = PRODW'(s_q) * PRODW'(g_cl);
    prod_sh = prod[PRODW-1:GF];
    // Anything above the price range saturates; S=0 stays 0 since 0*g = 0
    if (prod_sh > (PRODW-GF)'({PW{1'b1}})) f_s = {PW{1'b1}};
    else                                  f_s = prod_sh[PW-1:0];
    lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    s0_d     = s0_q;
    drift_d  = drift_q;
    vol_d    = vol_q;
    nsteps_d = nsteps_q;
    npaths_d = npaths_q;
    step_d   = step_q;
    pcnt_d   = pcnt_q;
    lfsr_d   = lfsr_q;
    path_d   = path_q;
    pv_d     = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        s0_d     = s0_i;
        drift_d  = drift_i;
        vol_d    = vol_i;
        nsteps_d = (n_steps_i == 8'd0) ? 8'd1 : n_steps_i;
        npaths_d = num_paths_i;
        lfsr_d   = (seed_i == 32'd0) ? LFSR_INIT : seed_i;
        s_d      = s0_i;
        step_d   = 8'd0;
        pcnt_d   = 16'd0;
        state_d  = (num_paths_i == 16'd0) ? DONE : STEP;
      end
      STEP: begin
        s_d    = f_s;
        lfsr_d = lfsr_nxt;
        step_d = step_q + 8'd1;
        if (step_q == nsteps_q - 8'd1) state_d = EMIT;
      end
      EMIT: begin
        path_d = s_q;
        pv_d   = 1'b1;
        pcnt_d = pcnt_q + 16'd1;
        if (pcnt_q == npaths_q - 16'd1) begin
          state_d = DONE;
        end else begin
          s_d     = s0_q;
          step_d  = 8'd0;
          state_d = STEP;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= '0;
      s0_q     <= '0;
      drift_q  <= '0;
      vol_q    <= '0;
      nsteps_q <= '0;
      npaths_q <= '0;
      step_q   <= '0;
      pcnt_q   <= '0;
      lfsr_q   <= LFSR_INIT;
      path_q   <= '0;
      pv_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      s0_q     <= s0_d;
      drift_q  <= drift_d;
      vol_q    <= vol_d;
      nsteps_q <= nsteps_d;
      npaths_q <= npaths_d;
      step_q   <= step_d;
      pcnt_q   <= pcnt_d;
      lfsr_q   <= lfsr_d;
      path_q   <= path_d;
      pv_q     <= pv_d;
      done_q   <= done_d;
    end
  end

  assign path_o       = path_q;
  assign path_valid_o = pv_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_mc_path_gen.sv
// Directed bench for mc_path_gen: timing, fixed-point update, saturation, LFSR paths, reset abort.
module tb_mc_path_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] s0 = '0;
  logic [15:0] drift = '0;
  logic [11:0] vol = '0;
  logic [7:0]  n_steps = '0;
  logic [15:0] num_paths = '0;
  logic [31:0] seed = '0;
  logic [11:0] path;
  logic        path_valid, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  mc_path_gen dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .s0_i(s0), .drift_i(drift),
    .vol_i(vol), .n_steps_i(n_steps), .num_paths_i(num_paths), .seed_i(seed),
    .path_o(path), .path_valid_o(path_valid), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Drive a start pulse; returns #1 after the sampling edge.
  task automatic do_start(input logic [11:0] a_s0, input logic [15:0] a_drift,
                          input logic [11:0] a_vol, input logic [7:0] a_n,
                          input logic [15:0] a_np, input logic [31:0] a_seed);
    @(negedge clk);
    s0 = a_s0; drift = a_drift; vol = a_vol; n_steps = a_n; num_paths = a_np; seed = a_seed;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Edges until path_valid (sampled #1 after each edge); cyc=999 on timeout.
  task automatic wait_pv(output int cyc, output logic [11:0] val);
    cyc = 0; val = '0;
    forever begin
      @(posedge clk); #1; cyc++;
      if (path_valid) begin val = path; break; end
      if (cyc > 400) begin cyc = 999; break; end
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    forever begin
      @(posedge clk); #1; cyc++;
      if (done) break;
      if (cyc > 400) begin cyc = 999; break; end
    end
  endtask

  function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic test_reset();
    n_checks++;
    if ({path, path_valid, busy, done} !== 15'd0) begin
      n_fail++; $display("FAIL reset_outputs: got path=%0d pv=%0b busy=%0b done=%0b, want all 0",
                         path, path_valid, busy, done);
    end
  endtask

  task automatic test_flat();
    int cyc; logic [11:0] v;
    do_start(12'd1000, 16'd0, 12'd0, 8'd5, 16'd3, 32'd7);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL flat_busy: got %0b want 1", busy); end
    for (int p = 0; p < 3; p++) begin
      wait_pv(cyc, v);
      n_checks++;
      if (cyc !== 6) begin n_fail++; $display("FAIL flat_gap[%0d]: got %0d edges want 6", p, cyc); end
      n_checks++;
      if (v !== 12'd1000) begin n_fail++; $display("FAIL flat_path[%0d]: got %0d want 1000", p, v); end
    end
    wait_done(cyc);
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("FAIL flat_done_lat: got %0d want 1", cyc); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flat_busy_after: got %0b want 0", busy); end
  endtask

  task automatic test_drift();
    int cyc; logic [11:0] v;
    do_start(12'd1024, 16'h0400, 12'd0, 8'd2, 16'd1, 32'd1);
    wait_pv(cyc, v);
    n_checks++;
    if (v !== 12'd1156) begin n_fail++; $display("FAIL drift_path: got %0d want 1156", v); end
    n_checks++;
    if (cyc !== 3) begin n_fail++; $display("FAIL drift_lat: got %0d want 3", cyc); end
    wait_done(cyc);
  endtask

  task automatic test_saturate();
    int cyc; logic [11:0] v;
    do_start(12'd4000, 16'd16384, 12'd0, 8'd1, 16'd1, 32'd1);
    wait_pv(cyc, v);
    n_checks++;
    if (v !== 12'd4095) begin n_fail++; $display("FAIL sat_high: got %0d want 4095", v); end
    wait_done(cyc);
    do_start(12'd4000, 16'h8000, 12'd0, 8'd3, 16'd1, 32'd1);
    wait_pv(cyc, v);
    n_checks++;
    if (v !== 12'd0) begin n_fail++; $display("FAIL sat_zero: got %0d want 0", v); end
    wait_done(cyc);
  endtask

  task automatic test_seed();
    logic [31:0] seeds [3];
    logic [31:0] l;
    longint s, z, g;
    int cyc; logic [11:0] v, ex;
    seeds[0] = 32'h1; seeds[1] = 32'h1; seeds[2] = 32'h0;
    for (int r = 0; r < 3; r++) begin
      l = (seeds[r] == 0) ? 32'hACE12468 : seeds[r];
      do_start(12'd2000, 16'd0, 12'd200, 8'd4, 16'd4, seeds[r]);
      for (int p = 0; p < 4; p++) begin
        s = 2000;
        for (int k = 0; k < 4; k++) begin
          z = longint'(l[3:0]) + longint'(l[7:4]) + longint'(l[11:8]) + longint'(l[15:12]) - 30;
          g = 16384 + 0 + 200 * z;
          if (g < 0) g = 0;
          if (g > 65535) g = 65535;
          s = (s * g) >>> 14;
          if (s > 4095) s = 4095;
          l = lfsr_adv(l);
        end
        ex = 12'(s);
        wait_pv(cyc, v);
        n_checks++;
        if (v !== ex || cyc !== 5) begin
          n_fail++; $display("FAIL seed_path[r%0d p%0d]: got %0d after %0d edges want %0d after 5",
                             r, p, v, cyc, ex);
        end
      end
      wait_done(cyc);
    end
  endtask

  task automatic test_edge_counts();
    int cyc; logic [11:0] v; int pvs;
    do_start(12'd1000, 16'd0, 12'd0, 8'd5, 16'd0, 32'd1);
    pvs = 0; cyc = 0;
    forever begin
      @(posedge clk); #1; cyc++;
      if (path_valid) pvs++;
      if (done || cyc > 50) break;
    end
    n_checks++;
    if (cyc !== 1 || pvs !== 0) begin
      n_fail++; $display("FAIL np0: got done after %0d edges with %0d paths, want 1 and 0", cyc, pvs);
    end
    do_start(12'd1024, 16'h0400, 12'd0, 8'd0, 16'd1, 32'd1);
    wait_pv(cyc, v);
    n_checks++;
    if (v !== 12'd1088 || cyc !== 2) begin
      n_fail++; $display("FAIL nsteps0: got %0d after %0d edges want 1088 after 2", v, cyc);
    end
    wait_done(cyc);
  endtask

  task automatic test_reset_abort();
    int pvs, dns; logic bad;
    do_start(12'd1000, 16'd0, 12'd0, 8'd5, 16'd3, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({path, path_valid, busy, done} !== 15'd0) begin
      n_fail++; $display("FAIL abort_outputs: got path=%0d pv=%0b busy=%0b done=%0b want 0",
                         path, path_valid, busy, done);
    end
    @(negedge clk); rst_n = 1'b1;
    pvs = 0; dns = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (path_valid) pvs++;
      if (done) dns++;
    end
    n_checks++;
    if (pvs !== 0 || dns !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_quiet: got pv=%0d done=%0d busy=%0b want 0 0 0", pvs, dns, busy);
    end
    // Second start mid-run must be ignored (s0 and num_paths stay latched)
    do_start(12'd500, 16'd0, 12'd0, 8'd3, 16'd2, 32'd1);
    pvs = 0; dns = 0; bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c == 2) begin s0 = 12'd900; num_paths = 16'd5; n_steps = 8'd1; start = 1'b1; end
      if (c == 3) start = 1'b0;
      @(posedge clk); #1;
      if (path_valid) begin pvs++; if (path !== 12'd500) bad = 1'b1; end
      if (done) dns++;
    end
    n_checks++;
    if (pvs !== 2 || dns !== 1 || bad) begin
      n_fail++; $display("FAIL busy_start: got pv=%0d done=%0d badval=%0b want 2 1 0", pvs, dns, bad);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_flat();
    test_drift();
    test_saturate();
    test_seed();
    test_edge_counts();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
